// File: rtl/mem_store_queue_mc.sv
// Multi-channel posted-write store queue: per-channel (addr, data) FIFOs drained
// through one round-robin valid/ready port. Capture is on the wr_en edge or level.
module mem_store_queue_mc #(
    parameter int NUM_CH    = 2,
    parameter int DEPTH     = 16,
    parameter int DW        = 8,
    parameter int AW        = 16,
    parameter int EDGE_MODE = 1,
    localparam int PW = $clog2(DEPTH),
    localparam int LW = PW + 1,
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    wr_en,
    input  logic [NUM_CH*DW-1:0] wr_data,
    input  logic [NUM_CH*AW-1:0] wr_addr,
    input  logic                 rd_ready,
    output logic                 rd_valid,
    output logic [DW-1:0]        rd_data,
    output logic [AW-1:0]        rd_addr,
    output logic [CW-1:0]        rd_ch,
    output logic [NUM_CH-1:0]    full,
    output logic [NUM_CH-1:0]    empty,
    output logic [NUM_CH-1:0]    overflow,
    input  logic [NUM_CH-1:0]    clr_overflow,
    output logic [NUM_CH*LW-1:0] level
);

    logic [DW-1:0]     data_q [NUM_CH][DEPTH];
    logic [DW-1:0]     data_d [NUM_CH][DEPTH];
    logic [AW-1:0]     addr_q [NUM_CH][DEPTH];
    logic [AW-1:0]     addr_d [NUM_CH][DEPTH];
    logic [PW-1:0]     head_q [NUM_CH];
    logic [PW-1:0]     head_d [NUM_CH];
    logic [PW-1:0]     tail_q [NUM_CH];
    logic [PW-1:0]     tail_d [NUM_CH];
    logic [LW-1:0]     level_q [NUM_CH];
    logic [LW-1:0]     level_d [NUM_CH];
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [NUM_CH-1:0] wr_en_prev_q, wr_en_prev_d;
    logic [CW-1:0]     rr_q, rr_d;

    logic [NUM_CH-1:0] non_empty;
    logic [NUM_CH-1:0] capture;
    logic [NUM_CH-1:0] pop;
    logic [CW-1:0]     sel;
    logic              found;
    logic              xfer;

    // Round-robin pick: first non-empty channel at or after rr_q, with wrap.
    always_comb begin
        non_empty = '0;
        found     = 1'b0;
        sel       = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            non_empty[c] = (level_q[c] != '0);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!found && (c == (int'(rr_q) + i) % NUM_CH) && non_empty[c]) begin
                    found = 1'b1;
                    sel   = CW'(c);
                end
            end
        end
    end

    always_comb begin
        rd_valid = found && !rst;
        rd_ch    = sel;
        rd_data  = '0;
        rd_addr  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (found && (sel == CW'(c))) begin
                rd_data = data_q[c][head_q[c]];
                rd_addr = addr_q[c][head_q[c]];
            end
        end
        xfer = rd_valid && rd_ready;
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            full[c]              = (level_q[c] == LW'(DEPTH));
            empty[c]             = (level_q[c] == '0);
            level[c*LW +: LW]    = level_q[c];
        end
        overflow = ovf_q;
    end

    // Full is judged on the registered level, so a pop in the same cycle
    // does not make room for a capture.
    always_comb begin
        data_d       = data_q;
        addr_d       = addr_q;
        head_d       = head_q;
        tail_d       = tail_q;
        level_d      = level_q;
        ovf_d        = ovf_q & ~clr_overflow;
        wr_en_prev_d = wr_en;
        rr_d         = rr_q;
        capture      = '0;
        pop          = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            capture[c] = (EDGE_MODE != 0) ? (wr_en[c] && !wr_en_prev_q[c]) : wr_en[c];
            pop[c]     = xfer && (sel == CW'(c));
            if (capture[c] && full[c]) begin
                ovf_d[c] = 1'b1;
            end else if (capture[c]) begin
                data_d[c][tail_q[c]] = wr_data[c*DW +: DW];
                addr_d[c][tail_q[c]] = wr_addr[c*AW +: AW];
                tail_d[c]            = tail_q[c] + PW'(1);
            end
            if (pop[c]) begin
                head_d[c] = head_q[c] + PW'(1);
            end
            if (capture[c] && !full[c] && !pop[c]) begin
                level_d[c] = level_q[c] + LW'(1);
            end else if (pop[c] && !(capture[c] && !full[c])) begin
                level_d[c] = level_q[c] - LW'(1);
            end
        end
        if (xfer) begin
            rr_d = (sel == CW'(NUM_CH - 1)) ? '0 : sel + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                head_q[c]  <= '0;
                tail_q[c]  <= '0;
                level_q[c] <= '0;
            end
            ovf_q        <= '0;
            wr_en_prev_q <= '0;
            rr_q         <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            level_q      <= level_d;
            ovf_q        <= ovf_d;
            wr_en_prev_q <= wr_en_prev_d;
            rr_q         <= rr_d;
        end
    end

    // Storage is qualified by level, so it needs no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        addr_q <= addr_d;
    end

endmodule

// File: doc/mem_store_queue_mc.md
Name: mem_store_queue_mc

Overview:
- Multi-channel posted-write buffer between CPU-side bus masters (6502 core, debug/loader port, future second CPU) and shared BRAM/peripheral write ports.
- Each channel has its own FIFO of (addr, data) entries.
- One round-robin drain port with a valid/ready handshake feeds the address decoder's write path.
- Replaces the single-channel, fixed-width 128-entry queue; adds width/depth/channel parametrisation, selectable edge or level capture, sticky overflow flags and fill levels.

Parameters:
- NUM_CH, 2, number of independent write channels (1..8)
- DEPTH, 16, entries per channel FIFO; must be a power of 2, at least 2
- DW, 8, data width
- AW, 16, address width
- EDGE_MODE, 1, 1 = capture on wr_en rising edge; 0 = capture every cycle wr_en is high

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_en  in  NUM_CH  per-channel write strobe
- wr_data  in  NUM_CH*DW  channel c occupies bits [c*DW +: DW]
- wr_addr  in  NUM_CH*AW  channel c occupies bits [c*AW +: AW]
- rd_ready  in  1  downstream can accept a store this cycle
- rd_valid  out  1  a store is presented
- rd_data  out  DW  data of the presented store
- rd_addr  out  AW  address of the presented store
- rd_ch  out  $clog2(NUM_CH) (min 1)  source channel of the presented store
- full  out  NUM_CH  channel FIFO holds DEPTH entries
- empty  out  NUM_CH  channel FIFO holds 0 entries
- overflow  out  NUM_CH  sticky: a capture was dropped because the FIFO was full
- clr_overflow  in  NUM_CH  clears the matching overflow bit
- level  out  NUM_CH*($clog2(DEPTH)+1)  per-channel occupancy

Behaviour:
- Clock and reset: rst is synchronous active-high; clock is clk.
- Reset state: all FIFOs empty, all pointers 0, level 0, empty all ones, full 0, overflow 0, RR pointer 0, edge-history registers 0.
  - rd_valid is 0 during and after reset until a capture occurs.
  - rd_data/rd_addr are 0 while empty.
- Capture event, channel c:
  - EDGE_MODE=1: wr_en[c] is high and was low on the previous cycle. wr_en held high across reset release counts as an edge on the first post-reset cycle.
  - EDGE_MODE=0: wr_en[c] is high.
- Capture with full[c]=0: write wr_addr/wr_data into the tail entry, tail increments (wraps modulo DEPTH), level increments.
- Capture with full[c]=1: entry dropped and overflow[c] set, including when the same channel is popped in that cycle. full is evaluated at the start of the cycle.
- clr_overflow[c] in the same cycle as a new drop: set wins.
- Drain selection (combinational):
  - Search channels starting at the RR pointer, ascending with wrap; the first non-empty channel is selected.
  - rd_valid = any channel non-empty; rd_ch/rd_addr/rd_data show that channel's head entry.
- Transfer occurs when rd_valid && rd_ready. The selected channel's head increments and level decrements. The RR pointer becomes (rd_ch+1) mod NUM_CH.
- No transfer: the RR pointer holds. Outputs may change only when a new capture makes a higher-priority channel non-empty.
- Capture and transfer on the same channel and cycle (not full): level unchanged, both pointers advance.
- Latency: a capture in cycle N is visible on rd_* in cycle N+1. Throughput is one transfer per cycle across all channels.
- Ordering: FIFO within a channel. Round-robin across channels, each non-empty channel drained at least once every NUM_CH transfers.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. full/empty derive from level, not pointer equality.
- rd_* outputs are combinational from registered state. There is no combinational path from rd_ready to rd_valid/rd_data/rd_addr/rd_ch.
- Reset mid-operation discards all pending entries. No transfer is reported in the reset cycle.

Test Plan:
- Reset, then EDGE_MODE=1: pulse wr_en[0] three times with addr 0x4800/0x2000/0x0100, data 0x11/0x22/0x33, rd_ready=0 -> level[0]=3, empty[0]=0. Then rd_ready=1 -> three consecutive transfers in that order, then rd_valid=0.
- EDGE_MODE=1, hold wr_en[1] high 5 cycles -> exactly one entry. EDGE_MODE=0, hold wr_en[1] high 5 cycles -> 5 entries.
- DEPTH=16: 17 captures on ch0 with no drain -> full[0]=1, 16 entries, overflow[0]=1. Pulse clr_overflow[0] -> overflow[0]=0; the 17th entry is never output.
- Both channels loaded with 4 entries, rd_ready=1 continuously -> rd_ch sequence 0,1,0,1,0,1,0,1. Per-channel data order preserved.
- Ch0 at level 2 (not full): capture and transfer on ch0 in the same cycle -> level stays 2 and data order is correct. Same test at full -> pop occurs, capture dropped, overflow set, level 15.
- Assert rst with 5 entries pending and rd_ready=1 -> next cycle all empty, rd_valid=0, level 0, overflow 0.
